// File: rtl/uart_alu_if_pkg.sv
// Shared definitions for the UART-to-ALU frame bridge:
// FSM state encoding and ALU opcode constants.
package uart_alu_if_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_GET_B   = 3'd1;
   localparam logic [2:0] ST_GET_OP  = 3'd2;
   localparam logic [2:0] ST_LATCH   = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      GET_B   = ST_GET_B,
      GET_OP  = ST_GET_OP,
      LATCH   = ST_LATCH,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX
   } state_t;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_if_frame_timer.sv
// Idle-clock counter for partial frames; expire is high on the
// cycle the count reaches CYCLES-1 while enabled.
module frame_timer #(
   parameter int unsigned CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt;

   assign expire = enable && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expire)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_alu_if.sv
// Collects A, B, opcode bytes from a UART, presents them to an ALU and
// sends the result back. Define UART_ALU_IF_TIMEOUT_EN to drop stale frames.
module uart_alu_if
   import uart_alu_if_pkg::*;
#(
   parameter int          NB_DATA        = 8,
   parameter int          NB_OP          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_busy,
   output logic               o_frame_err
);

   state_t state, state_nx;
   logic   expire;

`ifdef UART_ALU_IF_TIMEOUT_EN
   frame_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (i_clk),
      .rst    (i_reset),
      .clear  (i_rx_done || (state == IDLE)),
      .enable ((state == GET_B) || (state == GET_OP)),
      .expire (expire)
   );

   // A byte arriving on the expiry cycle keeps the frame alive
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         o_frame_err <= 1'b0;
      else
         o_frame_err <= expire && !i_rx_done;
   end
`else
   assign expire      = 1'b0;
   assign o_frame_err = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (i_rx_done) state_nx = GET_B;
         GET_B:   if (i_rx_done) state_nx = GET_OP;
                  else if (expire) state_nx = IDLE;
         GET_OP:  if (i_rx_done) state_nx = LATCH;
                  else if (expire) state_nx = IDLE;
         LATCH:   state_nx = SEND;
         SEND:    state_nx = WAIT_TX;
         WAIT_TX: if (i_tx_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_data_a   <= '0;
         o_data_b   <= '0;
         o_op       <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         if (state == IDLE && i_rx_done)
            o_data_a <= i_rx_data;
         if (state == GET_B && i_rx_done)
            o_data_b <= i_rx_data;
         if (state == GET_OP && i_rx_done)
            o_op <= i_rx_data[NB_OP-1:0];
         // Result has had the whole LATCH cycle to settle
         if (state == SEND) begin
            o_tx_data  <= i_alu_result;
            o_tx_start <= 1'b1;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: doc/uart_alu_if.md
UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: width of the UART byte, the operands and the result.
REQ-002 SHALL have parameter NB_OP, default 6: opcode width; the low NB_OP bits of the opcode byte are used.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10_000_000: idle clocks before a partial frame is dropped (used only with the macro in REQ-021).
REQ-004 SHALL have ports: i_clk  in  1  system clock; i_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: i_rx_data  in  NB_DATA  byte from uart_rx; i_rx_done  in  1  one-cycle strobe marking i_rx_data valid.
REQ-006 SHALL have ports: o_data_a  out  NB_DATA  operand A to ALU; o_data_b  out  NB_DATA  operand B to ALU; o_op  out  NB_OP  ALU opcode; i_alu_result  in  NB_DATA  combinational ALU result.
REQ-007 SHALL have ports: o_tx_data  out  NB_DATA  byte to uart_tx; o_tx_start  out  1  one-cycle send strobe; i_tx_done  in  1  one-cycle strobe from uart_tx.
REQ-008 SHALL have ports: o_busy  out  1  high outside IDLE; o_frame_err  out  1  one-cycle strobe when a partial frame is dropped.

Function
REQ-009 SHALL implement FSM states IDLE, GET_B, GET_OP, LATCH, SEND and WAIT_TX; the encoding is defined in the package.
REQ-010 In IDLE, on i_rx_done, SHALL load o_data_a with i_rx_data and move to GET_B.
REQ-011 In GET_B, on i_rx_done, SHALL load o_data_b and move to GET_OP.
REQ-012 In GET_OP, on i_rx_done, SHALL load o_op with i_rx_data[NB_OP-1:0] and move to LATCH.
REQ-013 LATCH SHALL last one cycle, so the ALU result settles from the registered operands, then move to SEND.
REQ-014 On entry to SEND, SHALL register i_alu_result into o_tx_data and assert o_tx_start for exactly one cycle, then move to WAIT_TX.
- Latency: o_tx_start goes high 2 cycles after the edge that samples the opcode i_rx_done.
REQ-015 In WAIT_TX, SHALL hold o_tx_data stable and return to IDLE on i_tx_done.
REQ-016 SHALL silently ignore i_rx_done strobes received in LATCH, SEND or WAIT_TX; no byte is queued.
REQ-017 If i_tx_done and i_rx_done coincide in WAIT_TX, SHALL go to IDLE and discard the byte.
REQ-018 Operands and opcode SHALL stay stable from their load until the next frame overwrites them.
REQ-019 o_busy SHALL be combinational: high when state is not IDLE.

Reset
REQ-020 While i_reset is high, asynchronously: state = IDLE, o_data_a = 0, o_data_b = 0, o_op = 0, o_tx_data = 0, o_tx_start = 0, o_frame_err = 0, timeout counter = 0; a reset mid-frame SHALL discard the partial frame and any pending send.

Configuration
REQ-021 With UART_ALU_IF_TIMEOUT_EN defined: in GET_B or GET_OP, count clocks since the last i_rx_done; on reaching TIMEOUT_CYCLES-1, SHALL return to IDLE and pulse o_frame_err for one cycle.
- The counter SHALL clear on every i_rx_done and on entry to IDLE.
- An i_rx_done on the expiry cycle wins: the byte is accepted and no error is raised.
REQ-022 Without UART_ALU_IF_TIMEOUT_EN: no counter is built, o_frame_err SHALL be tied to 0, and GET_B/GET_OP wait indefinitely.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding localparams and the opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111), shared with the ALU.
REQ-024 The timeout counter SHALL be a sub-module frame_timer (inputs clear/enable, output expire), instantiated only under the macro.

Verification
REQ-025 Bytes 0x05, 0x03, 0x20 (ADD) with the ALU model -> o_tx_data = 0x08 and one o_tx_start pulse exactly 2 cycles after the third i_rx_done; after i_tx_done, o_busy = 0.
REQ-026 Bytes 0x03, 0x05, 0xE2 (opcode bits 0x22, SUB) -> o_op = 0x22 and o_tx_data = 0xFE.
REQ-027 A 4th byte during WAIT_TX, then i_tx_done -> the byte is ignored, state = IDLE, and the next byte loads o_data_a.
REQ-028 i_reset asserted after the 2nd byte -> all outputs 0 immediately (asynchronous), and a fresh 3-byte frame works.
REQ-029 With the macro and TIMEOUT_CYCLES = 100: byte 0x05 then 100 idle clocks -> one-cycle o_frame_err and IDLE; a byte on the expiry cycle -> accepted, no error.
REQ-030 Without the macro: a 1000-cycle gap between bytes -> frame completes normally, o_frame_err stays 0.
